// File: rtl/intra_row_buf_ctrl.sv
// Intra LCU-row reference buffer controller: port A writes and picture-start clear, port B read bursts.
// Optional macro WR_RD_FWD_EN: forward colliding write data to the read path instead of stalling the read.
module intra_row_buf_ctrl #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  wr_req_i,
    input  logic [Addr_Width-1:0] wr_addr_i,
    input  logic [Word_Width-1:0] wr_data_i,
    output logic                  wr_ack_o,
    input  logic                  rd_start_i,
    input  logic [Addr_Width-1:0] rd_addr_i,
    input  logic [Addr_Width:0]   rd_len_i,
    output logic                  rd_busy_o,
    output logic                  rd_valid_o,
    output logic [Word_Width-1:0] rd_data_o,
    output logic                  rd_done_o,
    output logic                  cena_o,
    output logic                  wena_o,
    output logic                  oena_o,
    output logic [Addr_Width-1:0] addra_o,
    output logic [Word_Width-1:0] dataa_o,
    output logic                  cenb_o,
    output logic                  wenb_o,
    output logic                  oenb_o,
    output logic [Addr_Width-1:0] addrb_o,
    input  logic [Word_Width-1:0] ram_datab_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, CLEAR = 2'd2} state_t;

    localparam logic [Addr_Width-1:0] ADDR_ONE  = {{(Addr_Width-1){1'b0}}, 1'b1};
    localparam logic [Addr_Width-1:0] ADDR_LAST = {Addr_Width{1'b1}};
    localparam logic [Addr_Width:0]   CNT_ONE   = {{Addr_Width{1'b0}}, 1'b1};
    localparam logic [Addr_Width:0]   CNT_ZERO  = {(Addr_Width+1){1'b0}};

    state_t                  state_r;
    state_t                  state_s;
    logic [Addr_Width-1:0]   rd_addr_r;
    logic [Addr_Width:0]     rd_cnt_r;
    logic [Addr_Width-1:0]   clr_addr_r;
    logic                    valid_r;
    logic                    done_r;
    logic                    issue_s;
    logic                    coll_s;
    logic                    start_s;
    logic                    last_s;
`ifdef WR_RD_FWD_EN
    logic                    fwd_r;
    logic [Word_Width-1:0]   fwd_data_r;
`endif

    // Next-state decode; a collision stalls the read issue unless forwarding is built in.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        coll_s  = wr_req_i && (wr_addr_i == rd_addr_r);
        start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clr_i) begin
                    state_s = CLEAR;
                end else if (rd_start_i) begin
                    start_s = 1'b1;
                    if (rd_len_i != CNT_ZERO) begin
                        state_s = READ;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
`ifdef WR_RD_FWD_EN
                issue_s = 1'b1;
`else
                issue_s = !coll_s;
`endif
                if (issue_s && (rd_cnt_r == CNT_ONE)) begin
                    state_s = IDLE;
                end else begin
                    state_s = READ;
                end
            end
            CLEAR: begin
                if (clr_addr_r == ADDR_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign last_s = issue_s && (rd_cnt_r == CNT_ONE);

    // State, burst address/count, clear pointer and read-pipeline flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rd_addr_r  <= {Addr_Width{1'b0}};
            rd_cnt_r   <= CNT_ZERO;
            clr_addr_r <= {Addr_Width{1'b0}};
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            valid_r <= issue_s;
            done_r  <= last_s || (start_s && (rd_len_i == CNT_ZERO));
            if (start_s) begin
                rd_addr_r <= rd_addr_i;
                rd_cnt_r  <= rd_len_i;
            end else if (issue_s) begin
                rd_addr_r <= rd_addr_r + ADDR_ONE;
                rd_cnt_r  <= rd_cnt_r - CNT_ONE;
            end else begin
                rd_addr_r <= rd_addr_r;
                rd_cnt_r  <= rd_cnt_r;
            end
            if (state_r == CLEAR) begin
                clr_addr_r <= clr_addr_r + ADDR_ONE;
            end else begin
                clr_addr_r <= {Addr_Width{1'b0}};
            end
        end
    end

`ifdef WR_RD_FWD_EN
    // Capture write data that collided with an issued read, for use in the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_r      <= 1'b0;
            fwd_data_r <= {Word_Width{1'b0}};
        end else begin
            fwd_r      <= issue_s && coll_s;
            fwd_data_r <= wr_data_i;
        end
    end
`endif

    // Port A ownership: the clear sequencer overrides the writer while clearing.
    always_comb begin
        if (state_r == CLEAR) begin
            cena_o   = 1'b0;
            wena_o   = 1'b0;
            addra_o  = clr_addr_r;
            dataa_o  = {Word_Width{1'b0}};
            wr_ack_o = 1'b0;
        end else begin
            cena_o   = ~wr_req_i;
            wena_o   = ~wr_req_i;
            addra_o  = wr_addr_i;
            dataa_o  = wr_data_i;
            wr_ack_o = wr_req_i;
        end
    end

    // Read data is zero outside valid cycles.
    always_comb begin
`ifdef WR_RD_FWD_EN
        if (fwd_r) begin
            rd_data_o = fwd_data_r;
        end else if (valid_r) begin
            rd_data_o = ram_datab_i;
        end else begin
            rd_data_o = {Word_Width{1'b0}};
        end
`else
        if (valid_r) begin
            rd_data_o = ram_datab_i;
        end else begin
            rd_data_o = {Word_Width{1'b0}};
        end
`endif
    end

    assign oena_o     = 1'b1;
    assign oenb_o     = 1'b0;
    assign wenb_o     = 1'b1;
    assign cenb_o     = ~issue_s;
    assign addrb_o    = rd_addr_r;
    assign rd_valid_o = valid_r;
    assign rd_done_o  = done_r;
    assign rd_busy_o  = (state_r != IDLE) || valid_r;

endmodule

// File: tb/tb_intra_row_buf_ctrl.sv
// Directed bench for intra_row_buf_ctrl with a behavioural two-port RAM and a read-data scoreboard.
module tb_intra_row_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_i;
    logic        wr_req_i;
    logic [5:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        wr_ack_o;
    logic        rd_start_i;
    logic [5:0]  rd_addr_i;
    logic [6:0]  rd_len_i;
    logic        rd_busy_o, rd_valid_o, rd_done_o;
    logic [31:0] rd_data_o;
    logic        cena_o, wena_o, oena_o, cenb_o, wenb_o, oenb_o;
    logic [5:0]  addra_o, addrb_o;
    logic [31:0] dataa_o;
    logic [31:0] ram_q;
    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    int iss_q [$];
    int nvalid, first_v, last_v, ndone, done_cyc, gap, nissue, bad_data, nack;

    always #5 clk = ~clk;

    intra_row_buf_ctrl #(.Word_Width(32), .Addr_Width(6)) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_ack_o(wr_ack_o),
        .rd_start_i(rd_start_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i),
        .rd_busy_o(rd_busy_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_done_o(rd_done_o),
        .cena_o(cena_o), .wena_o(wena_o), .oena_o(oena_o), .addra_o(addra_o), .dataa_o(dataa_o),
        .cenb_o(cenb_o), .wenb_o(wenb_o), .oenb_o(oenb_o), .addrb_o(addrb_o), .ram_datab_i(ram_q)
    );

    // RAM model: read returns the pre-write contents on a same-address collision
    always @(posedge clk) begin
        if (!cena_o && !wena_o) mem[addra_o] <= dataa_o;
        if (!cenb_o) ram_q <= mem[addrb_o];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid read word is compared against the next expected word
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_unexpected_valid", 64'd1, 64'd0);
            else chk("sb_data", {32'd0, rd_data_o}, {32'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        wr_req_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        @(negedge clk);
        chk("wr_ack", {63'd0, wr_ack_o}, 64'd1);
        chk("wr_cena", {63'd0, cena_o}, 64'd0);
        tick();
        wr_req_i = 1'b0;
    endtask

    task automatic burst(input logic [5:0] a, input logic [6:0] len, input int wa_cyc,
                         input logic [5:0] wa, input logic [31:0] wd, input int ncyc);
        nvalid = 0; first_v = -1; last_v = -1; ndone = 0; done_cyc = -1;
        gap = 0; nissue = 0; bad_data = 0; nack = 0;
        iss_q.delete();
        for (int k = 0; k < ncyc; k++) begin
            rd_start_i = (k == 0); rd_addr_i = a; rd_len_i = len;
            wr_req_i = (k == wa_cyc); wr_addr_i = wa; wr_data_i = wd;
            @(negedge clk);
            if (rd_valid_o) begin
                if (last_v >= 0 && k != last_v + 1) gap++;
                if (first_v < 0) first_v = k;
                last_v = k;
                nvalid++;
            end else if (rd_data_o !== 32'd0) bad_data++;
            if (rd_done_o) begin ndone++; done_cyc = k; end
            if (!cenb_o) begin nissue++; iss_q.push_back(int'(addrb_o)); end
            if (wr_req_i && wr_ack_o) nack++;
            tick();
        end
        rd_start_i = 1'b0; wr_req_i = 1'b0;
    endtask

    task automatic chk_burst(input int ef, input int el, input int en, input int ed, input int eg);
        chk("first_valid", 64'(first_v), 64'(ef));
        chk("last_valid", 64'(last_v), 64'(el));
        chk("n_valid", 64'(nvalid), 64'(en));
        chk("done_cycle", 64'(done_cyc), 64'(ed));
        chk("n_done", 64'(ndone), 64'd1);
        chk("gaps", 64'(gap), 64'(eg));
        chk("idle_data_zero", 64'(bad_data), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_iss(input int start, input int n);
        chk("n_issue", 64'(nissue), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < iss_q.size()) chk("issue_addr", 64'(iss_q[i]), 64'((start + i) % 64));
            else chk("issue_missing", 64'd0, 64'd1);
        end
    endtask

    initial begin
        int busy_n, busy_first, busy_last, ack_n, cena_n;
        rst_n = 1'b0; clr_i = 1'b0; wr_req_i = 1'b0; wr_addr_i = 6'd0; wr_data_i = 32'd0;
        rd_start_i = 1'b0; rd_addr_i = 6'd0; rd_len_i = 7'd0;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", {63'd0, rd_busy_o}, 64'd0);
        chk("rst_valid_done", {62'd0, rd_valid_o, rd_done_o}, 64'd0);
        chk("rst_data", {32'd0, rd_data_o}, 64'd0);
        chk("rst_porta", {56'd0, wr_ack_o, cena_o, wena_o, oena_o, 4'd0}, {56'd0, 8'b0111_0000});
        chk("rst_portb", {61'd0, cenb_o, wenb_o, oenb_o}, 64'b110);
        chk("rst_addr", {40'd0, addra_o, addrb_o, 12'd0}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // basic burst
        wr(6'd5, 32'h11); wr(6'd6, 32'h22); wr(6'd7, 32'h33); wr(6'd8, 32'h44);
        exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33); exp_q.push_back(32'h44);
        burst(6'd5, 7'd4, -1, 6'd0, 32'd0, 8);
        chk_burst(2, 5, 4, 5, 0);
        chk_iss(5, 4);

        // address wrap 63 -> 0
        wr(6'd62, 32'hAAAA_0001); wr(6'd63, 32'hBBBB_0002); wr(6'd0, 32'hCCCC_0003); wr(6'd1, 32'hDDDD_0004);
        exp_q.push_back(32'hAAAA_0001); exp_q.push_back(32'hBBBB_0002);
        exp_q.push_back(32'hCCCC_0003); exp_q.push_back(32'hDDDD_0004);
        burst(6'd62, 7'd4, -1, 6'd0, 32'd0, 8);
        chk_burst(2, 5, 4, 5, 0);
        chk_iss(62, 4);

        // write/read collision on address 11 during its issue cycle
        wr(6'd10, 32'h1010); wr(6'd11, 32'h1111); wr(6'd12, 32'h1212);
        exp_q.push_back(32'h1010); exp_q.push_back(32'h5A); exp_q.push_back(32'h1212);
        burst(6'd10, 7'd3, 2, 6'd11, 32'h5A, 8);
`ifdef WR_RD_FWD_EN
        chk_burst(2, 4, 3, 4, 0);
`else
        chk_burst(2, 5, 3, 5, 1);
`endif
        chk_iss(10, 3);
        chk("coll_wr_ack", 64'(nack), 64'd1);

        // zero-length burst
        burst(6'd3, 7'd0, -1, 6'd0, 32'd0, 4);
        chk("zlen_done_cycle", 64'(done_cyc), 64'd1);
        chk("zlen_n_done", 64'(ndone), 64'd1);
        chk("zlen_valid", 64'(nvalid), 64'd0);
        chk("zlen_issue", 64'(nissue), 64'd0);

        // fill, then clear with writes attempted throughout
        for (int i = 0; i < 64; i++) begin
            wr_req_i = 1'b1; wr_addr_i = 6'(i); wr_data_i = 32'(i + 100);
            tick();
        end
        wr_req_i = 1'b0;
        busy_n = 0; busy_first = -1; busy_last = -1; ack_n = 0; cena_n = 0;
        for (int k = 0; k < 70; k++) begin
            clr_i = (k == 0);
            wr_req_i = (k >= 1 && k <= 64); wr_addr_i = 6'(k); wr_data_i = 32'hDEAD;
            @(negedge clk);
            if (rd_busy_o) begin
                busy_n++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
                if (!cena_o && !wena_o && dataa_o == 32'd0) cena_n++;
            end
            if (wr_ack_o) ack_n++;
            tick();
        end
        clr_i = 1'b0; wr_req_i = 1'b0;
        chk("clr_busy_cycles", 64'(busy_n), 64'd64);
        chk("clr_busy_first", 64'(busy_first), 64'd1);
        chk("clr_busy_last", 64'(busy_last), 64'd64);
        chk("clr_zero_writes", 64'(cena_n), 64'd64);
        chk("clr_wr_ack", 64'(ack_n), 64'd0);
        for (int i = 0; i < 64; i++) exp_q.push_back(32'd0);
        burst(6'd0, 7'd64, -1, 6'd0, 32'd0, 68);
        chk_burst(2, 65, 64, 65, 0);
        chk("clr_read_issue", 64'(nissue), 64'd64);

        // reset during word 2 of an 8-word burst
        rd_start_i = 1'b1; rd_addr_i = 6'd0; rd_len_i = 7'd8;
        tick();
        rd_start_i = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid_done_busy", {61'd0, rd_valid_o, rd_done_o, rd_busy_o}, 64'd0);
        chk("mid_rst_portb", {61'd0, cenb_o, wenb_o, oenb_o}, 64'b110);
        chk("mid_rst_data", {32'd0, rd_data_o}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rd_done_o || rd_valid_o || rd_busy_o) ndone++;
            tick();
        end
        chk("post_rst_quiet", 64'(ndone), 64'd0);
        exp_q.delete();
        wr(6'd20, 32'h2020); wr(6'd21, 32'h2121);
        exp_q.push_back(32'h2020); exp_q.push_back(32'h2121);
        burst(6'd20, 7'd2, -1, 6'd0, 32'd0, 6);
        chk_burst(2, 3, 2, 3, 0);
        chk_iss(20, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
